// File: rtl/alu.sv
// Signed two's-complement ALU: eight operations on NIO-bit operands,
// result and signed-overflow flag registered with one clock of latency.
module alu #(
    parameter int NIO = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic signed [NIO-1:0] A,
    input  logic signed [NIO-1:0] B,
    input  logic        [2:0]     OP,
    output logic signed [NIO-1:0] Z,
    output logic                  OV
);

    localparam int             SH_W  = $clog2(NIO);
    localparam logic [NIO-1:0] NIO_V = NIO'(NIO);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    function automatic logic add_ovf(input logic [NIO-1:0] a, input logic [NIO-1:0] b,
                                     input logic [NIO-1:0] s);
        return (a[NIO-1] == b[NIO-1]) && (s[NIO-1] != a[NIO-1]);
    endfunction

    function automatic logic sub_ovf(input logic [NIO-1:0] a, input logic [NIO-1:0] b,
                                     input logic [NIO-1:0] d);
        return (a[NIO-1] != b[NIO-1]) && (d[NIO-1] != a[NIO-1]);
    endfunction

    // A left shift by sh fits iff the top sh+1 bits of a all equal its sign bit.
    function automatic logic sll_ovf(input logic [NIO-1:0] a, input logic [SH_W-1:0] sh);
        logic ov;
        ov = 1'b0;
        for (int i = 0; i < NIO - 1; i++) begin
            ov = ov | ((i + int'(sh) >= NIO - 1) && (a[i] != a[NIO-1]));
        end
        return ov;
    endfunction

    logic signed [NIO-1:0] sum_s;
    logic signed [NIO-1:0] diff_s;
    logic        [SH_W-1:0] sh_s;
    logic                  in_range_s;
    logic signed [NIO-1:0] z_s;
    logic                  ov_s;
    logic signed [NIO-1:0] z_r;
    logic                  ov_r;

    // Combinational result and overflow for the current opcode.
    always_comb begin
        z_s        = {NIO{1'b0}};
        ov_s       = 1'b0;
        sum_s      = A + B;
        diff_s     = A - B;
        in_range_s = ($unsigned(B) < NIO_V);
        sh_s       = B[SH_W-1:0];
        case (OP)
            OP_ADD: begin
                z_s  = sum_s;
                ov_s = add_ovf(A, B, sum_s);
            end
            OP_SUB: begin
                z_s  = diff_s;
                ov_s = sub_ovf(A, B, diff_s);
            end
            OP_AND: z_s = A & B;
            OP_OR:  z_s = A | B;
            OP_XOR: z_s = A ^ B;
            OP_SLL: begin
                // Shifting by NIO or more only fits when A is zero.
                if (in_range_s) begin
                    z_s  = A << sh_s;
                    ov_s = sll_ovf(A, sh_s);
                end else begin
                    z_s  = {NIO{1'b0}};
                    ov_s = |A;
                end
            end
            OP_SRA: begin
                if (in_range_s) begin
                    z_s = A >>> sh_s;
                end else begin
                    z_s = {NIO{A[NIO-1]}};
                end
            end
            OP_SLT: z_s = {{(NIO-1){1'b0}}, (A < B)};
            default: begin
                z_s  = {NIO{1'b0}};
                ov_s = 1'b0;
            end
        endcase
    end

    // Output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_r  <= {NIO{1'b0}};
            ov_r <= 1'b0;
        end else begin
            z_r  <= z_s;
            ov_r <= ov_s;
        end
    end

    assign Z  = z_r;
    assign OV = ov_r;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: integer-arithmetic reference model checked every
// cycle, plus directed vectors with hand-computed results.
module tb_alu;

    localparam int N   = 8;
    localparam int NV  = 21;
    localparam longint MAXV = (longint'(1) << (N - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (N - 1));

    typedef struct {
        logic [2:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] z;
        logic         ov;
        string        name;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [2:0]   OP;
    logic [N-1:0] Z;
    logic         OV;

    int n_checks;
    int n_fail;

    logic [N-1:0] exp_z;
    logic         exp_ov;
    logic         exp_valid;
    logic [N-1:0] m_z;
    logic         m_ov;

    vec_t vecs [NV];

    alu #(.NIO(N)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (A),
        .B    (B),
        .OP   (OP),
        .Z    (Z),
        .OV   (OV)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer result, overflow when it leaves the signed range.
    function automatic void model(input logic [2:0] op, input logic [N-1:0] a,
                                  input logic [N-1:0] b, output logic [N-1:0] z,
                                  output logic ov);
        longint sa, sb, ub, res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'(b);
        res = 0;
        ov  = 1'b0;
        case (op)
            3'd0: begin res = sa + sb; ov = (res > MAXV) || (res < MINV); end
            3'd1: begin res = sa - sb; ov = (res > MAXV) || (res < MINV); end
            3'd2: res = longint'(a & b);
            3'd3: res = longint'(a | b);
            3'd4: res = longint'(a ^ b);
            3'd5: begin
                if (ub >= N) begin
                    res = 0;
                    ov  = (sa != 0);
                end else begin
                    res = sa * (longint'(1) << ub);
                    ov  = (res > MAXV) || (res < MINV);
                end
            end
            3'd6: res = sa >>> ((ub >= N) ? (N - 1) : ub);
            default: res = (sa < sb) ? 1 : 0;
        endcase
        z = res[N-1:0];
    endfunction

    // Model pipeline stage mirroring the one-cycle registered latency.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_z  <= '0;
            exp_ov <= 1'b0;
        end else begin
            model(OP, A, B, m_z, m_ov);
            exp_z  <= m_z;
            exp_ov <= m_ov;
        end
        exp_valid <= 1'b1;
    end

    initial exp_valid = 1'b0;

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (exp_valid) begin
            n_checks++;
            if (Z !== exp_z || OV !== exp_ov) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t op=%0d a=%h b=%h: got Z=%h OV=%b, want Z=%h OV=%b",
                         $time, OP, A, B, Z, OV, exp_z, exp_ov);
            end
        end
    end

    task automatic check(input string name, input logic [N-1:0] gz, input logic gov,
                         input logic [N-1:0] wz, input logic wov);
        n_checks++;
        if (gz !== wz || gov !== wov) begin
            n_fail++;
            $display("FAIL %s: got Z=%h OV=%b, want Z=%h OV=%b", name, gz, gov, wz, wov);
        end
    endtask

    // Called at a negedge: drive the vector, confirm outputs hold until the edge,
    // then check the registered result at the following negedge.
    task automatic run_vec(input vec_t v);
        logic [N-1:0] pz;
        logic         pov;
        pz  = Z;
        pov = OV;
        OP  = v.op;
        A   = v.a;
        B   = v.b;
        #1;
        check({v.name, "_hold"}, Z, OV, pz, pov);
        @(negedge clk);
        check(v.name, Z, OV, v.z, v.ov);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs = '{
            '{3'd1, 8'h05, 8'h03, 8'h02, 1'b0, "sub_5_3"},
            '{3'd1, 8'h03, 8'h05, 8'hFE, 1'b0, "sub_3_5"},
            '{3'd1, 8'h64, 8'h9C, 8'hC8, 1'b1, "sub_100_m100"},
            '{3'd1, 8'h80, 8'h01, 8'h7F, 1'b1, "sub_min_1"},
            '{3'd1, 8'h00, 8'h80, 8'h80, 1'b1, "sub_0_min"},
            '{3'd0, 8'h7F, 8'h01, 8'h80, 1'b1, "add_max_1"},
            '{3'd0, 8'h80, 8'hFF, 8'h7F, 1'b1, "add_min_m1"},
            '{3'd0, 8'hFD, 8'h05, 8'h02, 1'b0, "add_m3_5"},
            '{3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, "and"},
            '{3'd3, 8'hF0, 8'h3C, 8'hFC, 1'b0, "or"},
            '{3'd4, 8'hF0, 8'h3C, 8'hCC, 1'b0, "xor"},
            '{3'd7, 8'hFE, 8'h01, 8'h01, 1'b0, "slt_m2_1"},
            '{3'd7, 8'h01, 8'hFE, 8'h00, 1'b0, "slt_1_m2"},
            '{3'd6, 8'h80, 8'h03, 8'hF0, 1'b0, "sra_min_3"},
            '{3'd6, 8'hFF, 8'h09, 8'hFF, 1'b0, "sra_m1_9"},
            '{3'd6, 8'h7F, 8'h08, 8'h00, 1'b0, "sra_max_8"},
            '{3'd5, 8'h40, 8'h01, 8'h80, 1'b1, "sll_40_1"},
            '{3'd5, 8'h03, 8'h02, 8'h0C, 1'b0, "sll_3_2"},
            '{3'd5, 8'hFF, 8'h07, 8'h80, 1'b0, "sll_m1_7"},
            '{3'd5, 8'h01, 8'h08, 8'h00, 1'b1, "sll_1_8"},
            '{3'd5, 8'h00, 8'hC8, 8'h00, 1'b0, "sll_0_200"}
        };

        rst_n = 1'b0;
        OP    = 3'd0;
        A     = 8'h7F;
        B     = 8'h01;
        @(negedge clk);
        check("reset", Z, OV, 8'h00, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

        // Reset held for one edge in the middle of traffic.
        rst_n = 1'b0;
        OP    = 3'd0;
        A     = 8'h7F;
        B     = 8'h01;
        @(negedge clk);
        check("midreset", Z, OV, 8'h00, 1'b0);
        rst_n = 1'b1;
        run_vec('{3'd1, 8'h05, 8'h03, 8'h02, 1'b0, "resume"});
        run_vec('{3'd0, 8'h7F, 8'h01, 8'h80, 1'b1, "ov_set"});
        run_vec('{3'd2, 8'hFF, 8'hFF, 8'hFF, 1'b0, "ov_clear"});

        // Pseudo-random traffic, checked by the model process only.
        for (int i = 0; i < 200; i++) begin
            OP = 3'($urandom_range(0, 7));
            A  = 8'($urandom);
            B  = (i % 4 == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom);
            @(negedge clk);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
